// File: rtl/nibble_mul_seq_if.sv
// Operand/product handshake bundle for nibble_mul_seq: valid/ready on both sides.
// The master is the producer/consumer side; the slave is the multiplier.
interface nibble_mul_seq_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 5
) ();
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;
  logic               busy;
  logic [CNT_W-1:0]   iter;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product, busy, iter
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product, busy, iter
  );
endinterface

// File: rtl/nibble_mul_seq.sv
// Shift-add unsigned multiplier on one WIDTH-bit ripple adder; out_valid seen WIDTH+1 edges after accept.
// Backpressure: product held in DONE until out_ready; no new operands are taken until the result drains.
module nibble_mul_seq #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  nibble_mul_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q,     state_d;
  logic               carry_q,     carry_d;
  logic [WIDTH-2:0]   p_hi_rest_q, p_hi_rest_d;
  logic [WIDTH-1:0]   p_lo_q,      p_lo_d;
  logic [WIDTH-1:0]   m_q,         m_d;
  logic [CNT_W-1:0]   iter_q,      iter_d;
  logic               in_ready_q,  in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q,      busy_d;
  logic [2*WIDTH-1:0] product_q,   product_d;

  // The captured carry-out is the MSB of P_hi, so it is kept as its own flop.
  logic [WIDTH-1:0]   p_hi;
  logic [WIDTH-1:0]   add_y;
  logic [WIDTH-1:0]   add_sum;
  logic [WIDTH:0]     rc;
  logic               add_c;
  logic [2*WIDTH-1:0] p_next;

  assign p_hi = {carry_q, p_hi_rest_q};

  always_comb begin
    add_y   = p_lo_q[0] ? m_q : '0;
    add_sum = '0;
    rc      = '0;
    for (int i = 0; i < WIDTH; i++) begin
      add_sum[i] = p_hi[i] ^ add_y[i] ^ rc[i];
      rc[i+1]    = (p_hi[i] & add_y[i]) | (rc[i] & (p_hi[i] ^ add_y[i]));
    end
    add_c  = rc[WIDTH];
    p_next = {add_c, add_sum, p_lo_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d     = state_q;
    carry_d     = carry_q;
    p_hi_rest_d = p_hi_rest_q;
    p_lo_d      = p_lo_q;
    m_d         = m_q;
    iter_d      = iter_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    product_d   = product_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          m_d         = bus.a;
          p_lo_d      = bus.b;
          carry_d     = 1'b0;
          p_hi_rest_d = '0;
          iter_d      = '0;
          in_ready_d  = 1'b0;
          busy_d      = 1'b1;
          state_d     = CALC;
        end
      end
      CALC: begin
        {carry_d, p_hi_rest_d, p_lo_d} = p_next;
        if (iter_q == CNT_W'(WIDTH - 1)) begin
          iter_d      = '0;
          busy_d      = 1'b0;
          out_valid_d = 1'b1;
          product_d   = p_next;
          state_d     = DONE;
        end else begin
          iter_d = iter_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      carry_q     <= 1'b0;
      p_hi_rest_q <= '0;
      p_lo_q      <= '0;
      m_q         <= '0;
      iter_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      product_q   <= '0;
    end else begin
      state_q     <= state_d;
      carry_q     <= carry_d;
      p_hi_rest_q <= p_hi_rest_d;
      p_lo_q      <= p_lo_d;
      m_q         <= m_d;
      iter_q      <= iter_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      product_q   <= product_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.iter      = iter_q;
  assign bus.product   = product_q;

endmodule

// File: tb/tb_nibble_mul_seq.sv
// Directed and random checks of nibble_mul_seq at WIDTH=4 and WIDTH=8 against plain a*b.
module tb_nibble_mul_seq;
  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  logic [7:0] prev4;

  always #5 clk = ~clk;

  nibble_mul_seq_if #(.WIDTH(4), .CNT_W(5)) bus4 ();
  nibble_mul_seq_if #(.WIDTH(8), .CNT_W(5)) bus8 ();

  nibble_mul_seq #(.WIDTH(4), .CNT_W(5)) dut4 (.clk(clk), .reset(reset), .bus(bus4.slave));
  nibble_mul_seq #(.WIDTH(8), .CNT_W(5)) dut8 (.clk(clk), .reset(reset), .bus(bus8.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Full WIDTH=4 transaction: exact cycle-by-cycle expectations from accept to drain.
  task automatic run_op4(input logic [3:0] a, input logic [3:0] b, input int hold, input bit pulse);
    logic [7:0] exp;
    exp = 8'(int'(a) * int'(b));
    check("in_ready_idle", 32'(bus4.in_ready), 32'd1);
    bus4.in_valid = 1'b1;
    bus4.a = a;
    bus4.b = b;
    step();
    for (int k = 0; k < 4; k++) begin
      bus4.a = 4'($urandom);
      bus4.b = 4'($urandom);
      bus4.in_valid = 1'b0;
      if (pulse && k == 1) begin
        bus4.in_valid = 1'b1;
        bus4.a = 4'd3;
        bus4.b = 4'd3;
      end
      check("busy_calc", 32'(bus4.busy), 32'd1);
      check("iter_calc", 32'(bus4.iter), 32'(k));
      check("out_valid_calc", 32'(bus4.out_valid), 32'd0);
      check("in_ready_calc", 32'(bus4.in_ready), 32'd0);
      check("product_keep", 32'(bus4.product), 32'(prev4));
      step();
    end
    bus4.in_valid = 1'b0;
    // Accepted at edge N: out_valid is already high when sampled after edge N+4, i.e. present at edge N+5.
    check("out_valid_done", 32'(bus4.out_valid), 32'd1);
    check("product", 32'(bus4.product), 32'(exp));
    check("busy_done", 32'(bus4.busy), 32'd0);
    check("iter_done", 32'(bus4.iter), 32'd0);
    check("in_ready_done", 32'(bus4.in_ready), 32'd0);
    for (int h = 0; h < hold; h++) begin
      step();
      check("out_valid_hold", 32'(bus4.out_valid), 32'd1);
      check("product_hold", 32'(bus4.product), 32'(exp));
      check("in_ready_hold", 32'(bus4.in_ready), 32'd0);
    end
    bus4.out_ready = 1'b1;
    step();
    bus4.out_ready = 1'b0;
    check("out_valid_drained", 32'(bus4.out_valid), 32'd0);
    check("in_ready_after", 32'(bus4.in_ready), 32'd1);
    check("product_after", 32'(bus4.product), 32'(exp));
    prev4 = exp;
  endtask

  // Accept a pair, advance stop_k cycles (4 = sitting in DONE with backpressure), then reset.
  task automatic reset_mid(input logic [3:0] a, input logic [3:0] b, input int stop_k);
    bus4.in_valid = 1'b1;
    bus4.a = a;
    bus4.b = b;
    step();
    bus4.in_valid = 1'b0;
    for (int k = 0; k < stop_k; k++) step();
    if (stop_k < 4) check("iter_before_reset", 32'(bus4.iter), 32'(stop_k));
    else            check("out_valid_before_reset", 32'(bus4.out_valid), 32'd1);
    reset = 1'b1;
    bus4.out_ready = 1'b1;
    bus4.in_valid = 1'b1;
    step();
    reset = 1'b0;
    bus4.out_ready = 1'b0;
    bus4.in_valid = 1'b0;
    check("rst_in_ready", 32'(bus4.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus4.out_valid), 32'd0);
    check("rst_busy", 32'(bus4.busy), 32'd0);
    check("rst_iter", 32'(bus4.iter), 32'd0);
    check("rst_product", 32'(bus4.product), 32'd0);
    for (int k = 0; k < 8; k++) begin
      step();
      check("no_result_after_reset", 32'({bus4.out_valid, bus4.busy}), 32'd0);
    end
    prev4 = 8'd0;
  endtask

  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input int hold);
    logic [15:0] exp;
    int cyc;
    exp = 16'(int'(a) * int'(b));
    check("in_ready8_idle", 32'(bus8.in_ready), 32'd1);
    bus8.in_valid = 1'b1;
    bus8.a = a;
    bus8.b = b;
    step();
    bus8.in_valid = 1'b0;
    cyc = 0;
    while (bus8.out_valid !== 1'b1 && cyc < 20) begin
      bus8.a = 8'($urandom);
      bus8.b = 8'($urandom);
      step();
      cyc++;
    end
    check("latency8", 32'(cyc), 32'd8);
    check("product8", 32'(bus8.product), 32'(exp));
    for (int h = 0; h < hold; h++) begin
      step();
      check("product8_hold", 32'(bus8.product), 32'(exp));
    end
    bus8.out_ready = 1'b1;
    step();
    bus8.out_ready = 1'b0;
    check("out_valid8_drained", 32'(bus8.out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    bus4.in_valid = 1'b0; bus4.out_ready = 1'b0; bus4.a = '0; bus4.b = '0;
    bus8.in_valid = 1'b0; bus8.out_ready = 1'b0; bus8.a = '0; bus8.b = '0;
    prev4 = 8'd0;
    step();
    step();
    check("reset_in_ready", 32'(bus4.in_ready), 32'd1);
    check("reset_out_valid", 32'(bus4.out_valid), 32'd0);
    check("reset_busy", 32'(bus4.busy), 32'd0);
    check("reset_iter", 32'(bus4.iter), 32'd0);
    check("reset_product", 32'(bus4.product), 32'd0);
    check("reset_in_ready8", 32'(bus8.in_ready), 32'd1);
    reset = 1'b0;
    step();

    run_op4(4'd15, 4'd15, 0, 1'b0);
    run_op4(4'd10, 4'd12, 0, 1'b0);
    run_op4(4'd0,  4'd13, 0, 1'b0);
    run_op4(4'd1,  4'd9,  0, 1'b0);
    run_op4(4'd13, 4'd0,  1, 1'b0);
    run_op4(4'd7,  4'd6,  6, 1'b0);
    run_op4(4'd5,  4'd5,  0, 1'b1);
    reset_mid(4'd9, 4'd11, 2);
    run_op4(4'd9,  4'd11, 0, 1'b0);
    reset_mid(4'd7, 4'd6, 4);
    for (int n = 0; n < 20; n++) begin
      run_op4(4'($urandom), 4'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
    end

    run_op8(8'd255, 8'd255, 2);
    for (int n = 0; n < 10; n++) begin
      run_op8(8'($urandom), 8'($urandom), int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
